// File: rtl/module_return_task_decode.sv
// Streaming decoder for increment-and-clamp codes, with a 1-deep registered valid/ready output.
// Optional statistics counters are enabled by defining MODULE_RETURN_TASK_DECODE_STATS_EN.
module module_return_task_decode #(
   parameter int WIDTH = 8,
   parameter int LIMIT = 10,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       out_status,
   output logic             err_sticky
`ifdef MODULE_RETURN_TASK_DECODE_STATS_EN
   ,
   output logic [CNT_W-1:0] ok_count,
   output logic [CNT_W-1:0] ambig_count,
   output logic [CNT_W-1:0] invalid_count
`endif
);

   localparam logic [1:0]       ST_OK      = 2'b00;
   localparam logic [1:0]       ST_AMBIG   = 2'b01;
   localparam logic [1:0]       ST_INVALID = 2'b10;
   localparam logic [WIDTH-1:0] LIMIT_C    = WIDTH'(LIMIT);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t           state_q, state_d;
   logic             accept;
   logic             done;
   logic [WIDTH-1:0] dec_data;
   logic [1:0]       dec_status;

   // Zero means the encoder clamped, so the source value is lost rather than wrong.
   task automatic decode(input  logic [WIDTH-1:0] code,
                         output logic [WIDTH-1:0] data,
                         output logic [1:0]       status);
      data   = '0;
      status = ST_AMBIG;
      if (code == '0) return;
      status = ST_INVALID;
      if (code > LIMIT_C) return;
      data   = code - 1'b1;
      status = ST_OK;
   endtask

   assign out_valid = (state_q == FULL);
   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;
   assign done      = out_valid && out_ready;

   always_comb begin
      dec_data   = '0;
      dec_status = ST_OK;
      decode(in_data, dec_data, dec_status);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY:   if (accept) state_d = FULL;
         FULL:    if (done && !accept) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= EMPTY;
         out_data   <= '0;
         out_status <= ST_OK;
         err_sticky <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            out_data   <= dec_data;
            out_status <= dec_status;
            if (dec_status == ST_INVALID) err_sticky <= 1'b1;
         end
      end
   end

`ifdef MODULE_RETURN_TASK_DECODE_STATS_EN
   // Counters saturate at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         ok_count      <= '0;
         ambig_count   <= '0;
         invalid_count <= '0;
      end else if (accept) begin
         if (dec_status == ST_OK && ok_count != '1)
            ok_count <= ok_count + 1'b1;
         if (dec_status == ST_AMBIG && ambig_count != '1)
            ambig_count <= ambig_count + 1'b1;
         if (dec_status == ST_INVALID && invalid_count != '1)
            invalid_count <= invalid_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_module_return_task_decode.sv
// Self-checking bench for module_return_task_decode: directed scenarios plus a random
// stream scored against a transaction-level reference queue.
module tb_module_return_task_decode;

   localparam int WIDTH = 8;
   localparam int LIMIT = 10;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [1:0]       out_status;
   logic             err_sticky;
`ifdef MODULE_RETURN_TASK_DECODE_STATS_EN
   logic [CNT_W-1:0] ok_count, ambig_count, invalid_count;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   module_return_task_decode #(.WIDTH(WIDTH), .LIMIT(LIMIT), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_status (out_status),
      .err_sticky (err_sticky)
`ifdef MODULE_RETURN_TASK_DECODE_STATS_EN
      ,
      .ok_count      (ok_count),
      .ambig_count   (ambig_count),
      .invalid_count (invalid_count)
`endif
   );

   // Reference: the encoder is value+1 clamped to 0; invert it from the rules directly.
   function automatic logic [9:0] ref_decode(input int code);
      if (code == 0)     return {8'd0, 2'b01};
      if (code > LIMIT)  return {8'd0, 2'b10};
      return {8'(code - 1), 2'b00};
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      in_data   = 'x;
      out_ready = 1'b1;
      cycle();
   endtask

   task automatic send(input int code);
      in_valid  = 1'b1;
      in_data   = 8'(code);
      out_ready = 1'b1;
      cycle();
      in_valid  = 1'b0;
      in_data   = 'x;
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      in_data   = 'x;
      out_ready = 1'b0;
      rst       = 1'b1;
      cycle();
      rst       = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_status !== 2'b00 ||
          err_sticky !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset: got v=%b d=%0d s=%b e=%b r=%b want v=0 d=0 s=00 e=0 r=1",
                  out_valid, out_data, out_status, err_sticky, in_ready);
      end
   endtask

   task automatic test_ok();
      send(5);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'd4 || out_status !== 2'b00) begin
         errors++;
         $display("FAIL ok_5: got v=%b d=%0d s=%b want v=1 d=4 s=00", out_valid, out_data, out_status);
      end
   endtask

   task automatic test_ambig();
      send(0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'd0 || out_status !== 2'b01 || err_sticky !== 1'b0) begin
         errors++;
         $display("FAIL ambig_0: got v=%b d=%0d s=%b e=%b want v=1 d=0 s=01 e=0",
                  out_valid, out_data, out_status, err_sticky);
      end
   endtask

   task automatic test_invalid();
      int codes[2] = '{11, 255};
      foreach (codes[i]) begin
         send(codes[i]);
         checks++;
         if (out_valid !== 1'b1 || out_data !== 8'd0 || out_status !== 2'b10 || err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL invalid_%0d: got v=%b d=%0d s=%b e=%b want v=1 d=0 s=10 e=1",
                     codes[i], out_valid, out_data, out_status, err_sticky);
         end
      end
   endtask

   task automatic test_backpressure();
      drain();
      in_valid  = 1'b1;
      in_data   = 8'd3;
      out_ready = 1'b0;
      cycle();
      in_data   = 8'd7;  // offered but must not be taken while stalled
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== 8'd2 || out_status !== 2'b00 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_%0d: got v=%b d=%0d s=%b r=%b want v=1 d=2 s=00 r=0",
                     i, out_valid, out_data, out_status, in_ready);
         end
         cycle();
      end
      in_valid  = 1'b0;
      in_data   = 'x;
      out_ready = 1'b1;
      cycle();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stall_release: got v=%b want v=0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      drain();
      for (int i = 1; i <= 10; i++) begin
         in_valid  = 1'b1;
         in_data   = 8'(i);
         out_ready = 1'b1;
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_%0d: got r=%b want r=1", i, in_ready);
         end
         cycle();
         checks++;
         if (out_valid !== 1'b1 || out_data !== 8'(i - 1) || out_status !== 2'b00) begin
            errors++;
            $display("FAIL b2b_%0d: got v=%b d=%0d s=%b want v=1 d=%0d s=00",
                     i, out_valid, out_data, out_status, i - 1);
         end
      end
      drain();
   endtask

   task automatic test_rst_mid();
      in_valid  = 1'b1;
      in_data   = 8'd4;
      out_ready = 1'b0;
      cycle();
      in_valid  = 1'b0;
      in_data   = 'x;
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_full: got v=%b want v=1", out_valid);
      end
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_sticky !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid: got v=%b r=%b e=%b want v=0 r=1 e=0", out_valid, in_ready, err_sticky);
      end
   endtask

   task automatic test_random();
      logic [9:0] q[$];
      logic       m_err = 1'b0;
      bit         acc, dn;
      int         code;
      do_reset();
      for (int n = 0; n < 500; n++) begin
         checks++;
         if (out_valid !== (q.size() != 0) || err_sticky !== m_err) begin
            errors++;
            $display("FAIL rand_ctl_%0d: got v=%b e=%b want v=%b e=%b",
                     n, out_valid, err_sticky, q.size() != 0, m_err);
         end
         if (q.size() != 0) begin
            checks++;
            if ({out_data, out_status} !== q[0]) begin
               errors++;
               $display("FAIL rand_data_%0d: got d=%0d s=%b want d=%0d s=%b",
                        n, out_data, out_status, q[0][9:2], q[0][1:0]);
            end
         end
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(3) != 0);
         code      = ($urandom_range(7) == 0) ? int'($urandom_range(255)) : int'($urandom_range(12));
         in_data   = in_valid ? 8'(code) : 'x;
         #1;
         checks++;
         if (in_ready !== (q.size() == 0 || out_ready)) begin
            errors++;
            $display("FAIL rand_ready_%0d: got r=%b want r=%b", n, in_ready, q.size() == 0 || out_ready);
         end
         dn  = (q.size() != 0) && out_ready;
         acc = in_valid && (q.size() == 0 || out_ready);
         if (dn) void'(q.pop_front());
         if (acc) begin
            q.push_back(ref_decode(code));
            if (ref_decode(code) & 10'h2) m_err = 1'b1;
         end
         cycle();
      end
      drain();
   endtask

`ifdef MODULE_RETURN_TASK_DECODE_STATS_EN
   task automatic test_stats();
      do_reset();
      for (int i = 1; i <= 10; i++) send(i);
      send(0);
      send(11);
      drain();
      checks++;
      if (ok_count !== 16'd10 || ambig_count !== 16'd1 || invalid_count !== 16'd1) begin
         errors++;
         $display("FAIL stats_counts: got ok=%0d amb=%0d inv=%0d want 10/1/1",
                  ok_count, ambig_count, invalid_count);
      end
      in_valid  = 1'b1;
      in_data   = 8'd200;
      out_ready = 1'b1;
      for (int i = 0; i < (1 << CNT_W) + 3; i++) cycle();
      drain();
      checks++;
      if (invalid_count !== {CNT_W{1'b1}} || ok_count !== 16'd10) begin
         errors++;
         $display("FAIL stats_saturate: got inv=%0h ok=%0d want inv=ffff ok=10", invalid_count, ok_count);
      end
   endtask
`endif

   initial begin
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_data   = 'x;
      out_ready = 1'b0;
      test_reset();
      test_ok();
      test_ambig();
      test_invalid();
      test_backpressure();
      test_back_to_back();
      test_rst_mid();
      test_random();
`ifdef MODULE_RETURN_TASK_DECODE_STATS_EN
      test_stats();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
